coin_pulser: RTL and testbench
==============================

COIN_PULSER -- requirements
Module: coin_pulser

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 120000: number of consecutive stable cycles needed to accept an input change (10 ms at 12 MHz).
REQ-002 SHALL have parameter PULSE_CYC, default 600000: number of cycles coin_n_o is held low per credit (50 ms).
REQ-003 SHALL have parameter GAP_CYC, default 600000: minimum number of high cycles between two pulses on the same slot.
REQ-004 SHALL have parameter MAX_PEND, default 7: saturation limit of the pending-credit counter for each slot.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock (clk_12 domain); all logic is rising-edge.
REQ-006 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port coin_req_i, input, 2 bits: raw active-high coin buttons, one per slot; asynchronous to CLK.
REQ-008 SHALL have port enable_i, input, 1 bit: when 0, no new pulse starts and credits are held (used during ROM download).
REQ-009 SHALL have port coin_n_o, output, 2 bits: active-low coin pulses, one per slot, feeding Coin1_I and Coin2_I of the game core.
REQ-010 SHALL have port pend_o, output, 2 x clog2(MAX_PEND+1) bits: pending-credit count for each slot.
REQ-011 SHALL have port ovf_o, output, 2 bits: one-cycle strobe per slot, asserted when a credit is dropped at saturation.
REQ-012 SHALL have port busy_o, output, 1 bit: OR of "slot not IDLE or pend nonzero" over both slots.

Function
REQ-013 SHALL pass each coin_req_i bit through a two-flop synchronizer before any other use.
REQ-014 SHALL update the debounced level only after the synchronized input has differed from it for DEBOUNCE_CYC consecutive cycles; any return to the debounced level clears the stability counter.
REQ-015 SHALL generate a one-cycle accept strobe on each debounced 0->1 transition; debounced 1->0 transitions generate nothing.
REQ-016 SHALL, on an accept strobe, increment pend on the next edge; at pend=MAX_PEND it SHALL instead hold pend and pulse ovf_o for one cycle.
REQ-017 SHALL implement a per-slot FSM with states IDLE, PULSE and GAP.
REQ-018 In IDLE, when pend>0 and enable_i=1, the FSM SHALL decrement pend, load the timer and enter PULSE; coin_n_o goes low on that same edge.
REQ-019 In PULSE, coin_n_o SHALL be low for exactly PULSE_CYC cycles, then the FSM enters GAP.
REQ-020 In GAP, coin_n_o SHALL be high for exactly GAP_CYC cycles, then the FSM returns to IDLE.
REQ-021 An accept strobe in the same cycle as an IDLE decrement SHALL leave pend unchanged (net +1 -1); at MAX_PEND this case SHALL NOT set ovf_o.
REQ-022 enable_i=0 SHALL block only the IDLE->PULSE transition; a pulse or gap in progress completes, and credits still accumulate.
REQ-023 Slots SHALL be fully independent; both may pulse simultaneously.
REQ-024 Latency from a clean raw rise to coin_n_o falling, with the slot IDLE and enabled, SHALL be DEBOUNCE_CYC+4 cycles.
REQ-025 All counter arithmetic SHALL saturate; timers SHALL be sized clog2 of the larger of PULSE_CYC and GAP_CYC, and SHALL never wrap.

Reset
REQ-026 Assertion of Reset_n=0 SHALL asynchronously force the following, aborting any pulse in progress with no glitch low:
- coin_n_o=2'b11
- pend_o=0
- ovf_o=0
- busy_o=0
- FSM state IDLE
- synchronizers, debounced levels and timers cleared to 0
REQ-027 Deassertion SHALL be internally synchronized; the first accept is possible no earlier than DEBOUNCE_CYC cycles after release.

Structure
REQ-028 Package coin_pulser_pkg SHALL hold the FSM state enum (IDLE, PULSE, GAP) and the pend/timer width functions.
REQ-029 Sub-module coin_slot SHALL contain the synchronizer, debouncer, pend counter and FSM for one slot; coin_pulser SHALL instantiate it twice and form busy_o.

Verification
Bench parameters for all scenarios: DEBOUNCE_CYC=4, PULSE_CYC=8, GAP_CYC=6, MAX_PEND=3.
REQ-030 Latency: slot0 raw high for 20 cycles -> coin_n_o[0] low exactly 8 cycles after the rise for 8 cycles, then high; pend_o[0] reaches 1 and returns to 0.
REQ-031 Bounce rejection: slot1 toggling every 2 cycles for 30 cycles, then low -> no accept and coin_n_o[1] stays high.
REQ-032 Queueing and saturation: 5 clean presses on slot0 within one pulse period -> pend saturates at 3, ovf_o[0] strobes at least once, and exactly 4 pulses come out, each separated by 6 or more high cycles.
REQ-033 Enable gating: enable_i=0 with 2 presses -> pend=2 and no pulse; on enable_i=1 -> 2 pulses, the first beginning 1 cycle later.
REQ-034 Simultaneous events and reset: both slots pressed on the same cycle -> identical pulses; Reset_n low at the 3rd cycle of PULSE -> coin_n_o=11 and pend=0 immediately, with no further pulses after release.

Source files
------------

// File: rtl/coin_pulser_pkg.sv
// coin_pulser_pkg: shared slot FSM state type and width helpers for the coin pulser
package coin_pulser_pkg;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} slot_state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int pend_w(input int max_pend);
      return cnt_w(max_pend + 1);
   endfunction

   function automatic int tmr_w(input int pulse_cyc, input int gap_cyc);
      return cnt_w((pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc);
   endfunction

endpackage

// File: rtl/coin_slot.sv
// coin_slot: one coin slot - synchronizer, debouncer, pending-credit counter and pulse FSM
module coin_slot
   import coin_pulser_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 120000,
   parameter int PULSE_CYC    = 600000,
   parameter int GAP_CYC      = 600000,
   parameter int MAX_PEND     = 7
)(
   input  logic                          clk_sys,
   input  logic                          rst_n,
   input  logic                          coin_req,
   input  logic                          enable,
   output logic                          coin_n,
   output logic [pend_w(MAX_PEND)-1:0]   pend,
   output logic                          ovf,
   output logic                          busy
);

   localparam int PW = pend_w(MAX_PEND);
   localparam int TW = tmr_w(PULSE_CYC, GAP_CYC);
   localparam int DW = cnt_w(DEBOUNCE_CYC);
   localparam logic [PW-1:0] PMAX   = PW'(MAX_PEND);
   localparam logic [TW-1:0] P_LOAD = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] G_LOAD = TW'(GAP_CYC - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync;
   logic          deb;
   logic          deb_q;
   logic [DW-1:0] stab;
   logic [TW-1:0] tmr;
   slot_state_t   state;
   logic          acc;
   logic          dec;

   assign acc  = deb & ~deb_q;
   assign dec  = (state == IDLE) && (pend != '0) && enable;
   assign busy = (state != IDLE) || (pend != '0);

   // synchronize the raw button, then accept a new level only after it has held long enough
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         stab  <= '0;
      end else begin
         sync  <= {sync[0], coin_req};
         deb_q <= deb;
         if (sync[1] == deb)
            stab <= '0;
         else if (stab == D_LAST) begin
            deb  <= sync[1];
            stab <= '0;
         end else
            stab <= stab + DW'(1);
      end
   end

   // credit bookkeeping and pulse/gap sequencing; coin_n is driven straight from this register
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         tmr    <= '0;
         coin_n <= 1'b1;
         pend   <= '0;
         ovf    <= 1'b0;
      end else begin
         ovf <= acc && !dec && (pend == PMAX);
         if (acc && !dec && (pend != PMAX))
            pend <= pend + PW'(1);
         else if (dec && !acc)
            pend <= pend - PW'(1);
         case (state)
            IDLE:
               if (dec) begin
                  state  <= PULSE;
                  tmr    <= P_LOAD;
                  coin_n <= 1'b0;
               end
            PULSE:
               if (tmr != '0)
                  tmr <= tmr - TW'(1);
               else begin
                  state  <= GAP;
                  tmr    <= G_LOAD;
                  coin_n <= 1'b1;
               end
            GAP:
               if (tmr != '0)
                  tmr <= tmr - TW'(1);
               else
                  state <= IDLE;
            default: begin
               state  <= IDLE;
               coin_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/coin_pulser.sv
// coin_pulser: two independent debounced coin slots producing timed active-low coin pulses
module coin_pulser
   import coin_pulser_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 120000,
   parameter int PULSE_CYC    = 600000,
   parameter int GAP_CYC      = 600000,
   parameter int MAX_PEND     = 7
)(
   input  logic                            CLK,
   input  logic                            Reset_n,
   input  logic [1:0]                      coin_req_i,
   input  logic                            enable_i,
   output logic [1:0]                      coin_n_o,
   output logic [2*pend_w(MAX_PEND)-1:0]   pend_o,
   output logic [1:0]                      ovf_o,
   output logic                            busy_o
);

   localparam int PW = pend_w(MAX_PEND);

   logic [1:0] rst_sync;
   logic [1:0] busy;

   // assert reset immediately, release it only after two clean clock edges
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n)
         rst_sync <= '0;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end

   for (genvar i = 0; i < 2; i++) begin : g_slot
      coin_slot #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .PULSE_CYC    (PULSE_CYC),
         .GAP_CYC      (GAP_CYC),
         .MAX_PEND     (MAX_PEND)
      ) u_slot (
         .clk_sys  (CLK),
         .rst_n    (rst_sync[1]),
         .coin_req (coin_req_i[i]),
         .enable   (enable_i),
         .coin_n   (coin_n_o[i]),
         .pend     (pend_o[i*PW +: PW]),
         .ovf      (ovf_o[i]),
         .busy     (busy[i])
      );
   end

   assign busy_o = |busy;

endmodule

// File: tb/tb_coin_pulser.sv
// tb_coin_pulser: scoreboard bench for coin_pulser with short debounce/pulse/gap timing
module tb_coin_pulser;

   localparam int DEB  = 4;
   localparam int PUL  = 8;
   localparam int GAP  = 6;
   localparam int MAXP = 3;

   typedef struct {
      int start;
      int len;
   } pulse_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] coin_req = 2'b00;
   logic       en = 1'b1;
   logic [1:0] coin_n;
   logic [3:0] pend;
   logic [1:0] ovf;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   pulse_t exp_q0[$];
   pulse_t exp_q1[$];
   int   start[2]     = '{0, 0};
   int   last_rise[2] = '{-100, -100};
   int   ovf_cnt[2]   = '{0, 0};
   logic prev[2]      = '{1'b1, 1'b1};

   coin_pulser #(
      .DEBOUNCE_CYC (DEB),
      .PULSE_CYC    (PUL),
      .GAP_CYC      (GAP),
      .MAX_PEND     (MAXP)
   ) dut (
      .CLK        (clk),
      .Reset_n    (rst_n),
      .coin_req_i (coin_req),
      .enable_i   (en),
      .coin_n_o   (coin_n),
      .pend_o     (pend),
      .ovf_o      (ovf),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int s, input int st, input int ln);
      pulse_t p;
      p.start = st;
      p.len   = ln;
      if (s == 0) exp_q0.push_back(p);
      else        exp_q1.push_back(p);
   endtask

   task automatic end_pulse(input int s, input int ln);
      pulse_t e;
      if ((s == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
         check($sformatf("unexpected_pulse%0d", s), 1, 0);
      end else begin
         e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check($sformatf("pulse_start%0d", s), start[s], e.start);
         check($sformatf("pulse_len%0d", s), ln, e.len);
      end
   endtask

   // pulse monitor: measures each low pulse and the high gap before it
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         ovf_cnt[s] += int'(ovf[s]);
         if (prev[s] && !coin_n[s]) begin
            check($sformatf("gap_ok%0d", s), int'((cyc - last_rise[s]) >= GAP), 1);
            start[s] = cyc;
         end else if (!prev[s] && coin_n[s]) begin
            last_rise[s] = cyc;
            end_pulse(s, cyc - start[s]);
         end
         prev[s] = coin_n[s];
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [1:0] m);
      coin_req = m;
      tick(6);
      coin_req = 2'b00;
      tick(6);
   endtask

   initial begin
      int k;
      int e;
      tick(3);
      check("rst_coin", coin_n, 3);
      check("rst_pend", pend, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick(5);

      // latency of a single clean press
      k = cyc;
      push(0, k + DEB + 4, PUL);
      coin_req[0] = 1'b1;
      tick(7);
      check("lat_pend_one", pend[1:0], 1);
      check("lat_still_high", coin_n[0], 1);
      tick(1);
      check("lat_low", coin_n[0], 0);
      check("lat_pend_zero", pend[1:0], 0);
      check("lat_busy", busy, 1);
      tick(12);
      coin_req[0] = 1'b0;
      tick(30);
      check("lat_idle", busy, 0);

      // bouncing input on slot 1
      repeat (15) begin
         coin_req[1] = ~coin_req[1];
         tick(2);
      end
      coin_req[1] = 1'b0;
      tick(20);
      check("bounce_pend", pend[3:2], 0);
      check("bounce_coin", coin_n[1], 1);

      // queueing and saturation
      k = cyc;
      push(0, k + DEB + 4, PUL);
      press(2'b01);
      en = 1'b0;
      repeat (4) press(2'b01);
      tick(10);
      check("sat_pend", pend[1:0], MAXP);
      check("sat_ovf_cnt", ovf_cnt[0], 1);
      e = cyc;
      push(0, e + 1, PUL);
      push(0, e + 1 + PUL + GAP + 1, PUL);
      push(0, e + 1 + 2 * (PUL + GAP + 1), PUL);
      en = 1'b1;
      tick(50);
      check("sat_drained", pend[1:0], 0);

      // enable gating
      en = 1'b0;
      press(2'b01);
      press(2'b01);
      tick(5);
      check("gate_pend", pend[1:0], 2);
      check("gate_coin", coin_n[0], 1);
      e = cyc;
      push(0, e + 1, PUL);
      push(0, e + 1 + PUL + GAP + 1, PUL);
      en = 1'b1;
      tick(40);
      check("gate_drained", pend[1:0], 0);

      // simultaneous presses on both slots
      k = cyc;
      push(0, k + DEB + 4, PUL);
      push(1, k + DEB + 4, PUL);
      coin_req = 2'b11;
      tick(6);
      coin_req = 2'b00;
      tick(2);
      check("both_low", coin_n, 0);
      tick(30);

      // reset during the third cycle of a pulse
      en = 1'b0;
      press(2'b11);
      press(2'b01);
      tick(4);
      check("pre_rst_pend0", pend[1:0], 2);
      check("pre_rst_pend1", pend[3:2], 1);
      e = cyc;
      push(0, e + 1, 2);
      push(1, e + 1, 2);
      en = 1'b1;
      tick(3);
      rst_n = 1'b0;
      #1;
      check("abort_coin", coin_n, 3);
      check("abort_pend", pend, 0);
      check("abort_ovf", ovf, 0);
      check("abort_busy", busy, 0);
      tick(4);
      rst_n = 1'b1;
      tick(40);
      check("post_rst_coin", coin_n, 3);
      check("post_rst_pend", pend, 0);
      check("post_rst_busy", busy, 0);

      check("missing_pulses0", exp_q0.size(), 0);
      check("missing_pulses1", exp_q1.size(), 0);
      check("ovf1_cnt", ovf_cnt[1], 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
